univ_shift_seq: RTL and testbench
=================================

// Module: univ_shift_seq
// PURPOSE
//  Command-driven universal shift register: N-bit register with 8 ops (hold, logical/arith
//  shift, rotate, load, clear) and a multi-position shift amount executed one position/clk.
//  Valid/ready command port, serial in/out, done pulse. Sits between a control FSM/CSR and
//  a serialiser/datapath that needs bit-serial or barrel-like shifting without a barrel.
// PARAMETERS
//  N      8                Register width, N >= 2
//  AMT_W  $clog2(N)+1      Shift-amount width; amounts 0..2**AMT_W-1 legal (>= N allowed)
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      reset, synchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      block can accept command (= state IDLE)
//  cmd_op     in   3      shift_op_e: 0 HOLD,1 SHR,2 SHL,3 LOAD,4 ROTR,5 ROTL,6 ASR,7 CLR
//  cmd_amt    in   AMT_W  positions to shift (ignored for HOLD/LOAD/CLR)
//  din        in   N      parallel load data (sampled at accept edge only)
//  sin        in   1      serial fill bit for SHR (into MSB) / SHL (into LSB), sampled each shift edge
//  dout       out  N      register contents
//  sout       out  1      last bit shifted out (registered)
//  busy       out  1      multi-cycle op in progress (= ~cmd_ready)
//  done       out  1      1-cycle pulse: command complete, dout final
// BEHAVIOUR
//  - Reset: dout=0, sout=0, done=0, busy=0, cmd_ready=1, state IDLE, cnt=0, op reg=HOLD.
//  - Accept = cmd_valid & cmd_ready at a posedge; op latched; cmd_valid ignored while busy.
//  - FSM: IDLE, BUSY. IDLE->BUSY only on accept of shift op (SHR/SHL/ROTR/ROTL/ASR) with
//    amt>=2, cnt<=amt-1. BUSY: one shift/edge, cnt--; at edge with cnt==1 -> IDLE.
//  - Shift ops: first shift applied at accept edge; amt=k>0 -> k shifts on k consecutive
//    edges; done high in cycle after k-th edge; cmd_ready low for k-1 cycles. Back-to-back:
//    new command may be accepted in the done cycle.
//  - amt=0 shift op, HOLD: dout/sout unchanged; done pulses next cycle; no BUSY.
//  - LOAD: dout<=din at accept edge; CLR: dout<=0; sout unchanged; done next cycle.
//  - One-position step: SHR {sin,d[N-1:1]} out d[0]; SHL {d[N-2:0],sin} out d[N-1];
//    ROTR {d[0],d[N-1:1]} out d[0]; ROTL {d[N-2:0],d[N-1]} out d[N-1];
//    ASR {d[N-1],d[N-1:1]} out d[0]. sout<=out bit at every shift edge.
//  - Rotates with amt>=N just keep rotating (amt cycles, no modulo shortcut).
//  - done is never asserted in the same cycle as busy=1 except not at all: done=1 => busy=0.
//  - rst mid-op: aborts immediately, all reset values, no done pulse for aborted command.
//  - No X on outputs after reset regardless of cmd_* values while cmd_valid=0.
// STRUCTURE
//  - Package univ_shift_pkg: typedef enum logic [2:0] shift_op_e (codes above);
//    localparam SHIFT_OP_W=3; function is_shift_op(shift_op_e).
//  - Sub-module univ_shift_step #(N): combinational one-position step
//    (op, d, sin) -> (d_nxt, out_bit); top holds FSM, counter, dout/sout/done regs.
// TESTING  (N=8, AMT_W=4)
//  - rst=1 2 cycles with random cmd_* -> dout=00, sout=0, done=0, cmd_ready=1, busy=0.
//  - LOAD din=A5 -> next cycle dout=A5, done=1 for 1 cycle, cmd_ready stays 1; then
//    SHR amt=0 -> dout=A5 unchanged, done pulse.
//  - from A5, SHR amt=3 sin=1 -> cmd_ready low 2 cycles, after 3rd edge dout=F4, sout=1, done=1.
//  - from A5, ROTL amt=8, cmd_valid held high with LOAD 00 during busy -> dout=A5 after 8 edges,
//    done once, held LOAD accepted only in done cycle -> dout=00 next.
//  - LOAD 96, ASR amt=2 -> dout=E5, sout=1; then SHL amt=1 sin=0 -> dout=CA, sout=1.
//  - LOAD FF, SHL amt=6 sin=0, rst pulsed at 3rd shift cycle -> dout=00, IDLE, no done ever.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states
// and a helper that tells multi-position shift ops apart from single-cycle ops.
package univ_shift_pkg;

    localparam int SHIFT_OP_W = 3;

    typedef enum logic [SHIFT_OP_W-1:0] {
        OP_HOLD = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ROTR = 3'd4,
        OP_ROTL = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } shift_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } shift_state_e;

    function automatic logic is_shift_op(input shift_op_e op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROTR) ||
               (op == OP_ROTL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/univ_shift_step.sv
// Combinational single-position shift/rotate step. Non-shift ops pass the
// data through unchanged with a zero out bit.
module univ_shift_step
    import univ_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  shift_op_e      op,
    input  logic [N-1:0]   d,
    input  logic           sin,
    output logic [N-1:0]   d_nxt,
    output logic           out_bit
);

    always_comb begin
        d_nxt   = d;
        out_bit = 1'b0;
        case (op)
            OP_SHR: begin
                d_nxt   = {sin, d[N-1:1]};
                out_bit = d[0];
            end
            OP_SHL: begin
                d_nxt   = {d[N-2:0], sin};
                out_bit = d[N-1];
            end
            OP_ROTR: begin
                d_nxt   = {d[0], d[N-1:1]};
                out_bit = d[0];
            end
            OP_ROTL: begin
                d_nxt   = {d[N-2:0], d[N-1]};
                out_bit = d[N-1];
            end
            OP_ASR: begin
                d_nxt   = {d[N-1], d[N-1:1]};
                out_bit = d[0];
            end
            default: begin
                d_nxt   = d;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_seq.sv
// Command-driven universal shift register: executes multi-position shifts one
// position per clock, with a valid/ready command port and a done pulse.
module univ_shift_seq
    import univ_shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = $clog2(N) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SHIFT_OP_W-1:0] cmd_op,
    input  logic [AMT_W-1:0]      cmd_amt,
    input  logic [N-1:0]          din,
    input  logic                  sin,
    output logic [N-1:0]          dout,
    output logic                  sout,
    output logic                  busy,
    output logic                  done
);

    shift_state_e      state_q, state_d;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    shift_op_e         op_q, op_d;
    logic [N-1:0]      dout_q, dout_d;
    logic              sout_q, sout_d;
    logic              done_q, done_d;

    shift_op_e         cmd_op_e;
    shift_op_e         step_op;
    logic [N-1:0]      step_d;
    logic              step_out;
    logic              accept;

    assign cmd_op_e = shift_op_e'(cmd_op);
    assign accept   = cmd_valid && (state_q == S_IDLE);

    // The first shift happens on the accept edge, so the step sees the incoming op while idle.
    assign step_op  = (state_q == S_BUSY) ? op_q : cmd_op_e;

    univ_shift_step #(.N(N)) u_step (
        .op      (step_op),
        .d       (dout_q),
        .sin     (sin),
        .d_nxt   (step_d),
        .out_bit (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dout_d  = dout_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = cmd_op_e;
                    if (is_shift_op(cmd_op_e) && (cmd_amt != '0)) begin
                        dout_d = step_d;
                        sout_d = step_out;
                        if (cmd_amt > AMT_W'(1)) begin
                            state_d = S_BUSY;
                            cnt_d   = cmd_amt - AMT_W'(1);
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (cmd_op_e == OP_LOAD) begin
                        dout_d = din;
                        done_d = 1'b1;
                    end else if (cmd_op_e == OP_CLR) begin
                        dout_d = '0;
                        done_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                dout_d = step_d;
                sout_d = step_out;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            dout_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign dout      = dout_q;
    assign sout      = sout_q;
    assign done      = done_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_univ_shift_seq.sv
// Self-checking bench for univ_shift_seq (N=8, AMT_W=4): directed vector table,
// hand-written multi-cycle corner cases and randomized commands against a model.
module tb_univ_shift_seq;
    import univ_shift_pkg::*;

    localparam int N     = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [N-1:0]     din;
    logic             sin;
    logic [N-1:0]     dout;
    logic             sout;
    logic             busy;
    logic             done;

    int n_cmp;
    int n_err;

    logic [N-1:0] m_dout;
    logic         m_sout;

    univ_shift_seq #(.N(N), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .din       (din),
        .sin       (sin),
        .dout      (dout),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [AMT_W-1:0] amt;
        logic [N-1:0]     d;
        logic             s;
        logic [N-1:0]     exp_dout;
        logic             exp_sout;
        int               exp_wait;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, then wait for done and compare the completion state.
    task automatic apply_stimulus(input string name, input logic [2:0] op, input logic [AMT_W-1:0] amt,
                                  input logic [N-1:0] d, input logic s,
                                  input logic [N-1:0] exp_dout, input logic exp_sout, input int exp_wait);
        int waits;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        din       = d;
        sin       = s;
        step_clk();
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_amt   = AMT_W'($urandom);
        din       = N'($urandom);
        waits     = 0;
        while (!done && waits < 40) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                check_output({name, " busy"}, {30'd0, cmd_ready, busy}, 32'd1);
            end
            step_clk();
            waits++;
        end
        check_output({name, " done"}, 32'(done), 32'd1);
        check_output({name, " wait"}, 32'(waits), 32'(exp_wait));
        check_output({name, " dout"}, 32'(dout), 32'(exp_dout));
        check_output({name, " sout"}, 32'(sout), 32'(exp_sout));
        check_output({name, " idle"}, {30'd0, cmd_ready, busy}, 32'd2);
    endtask

    // Reference: whole-command result from shift arithmetic, updating m_dout/m_sout.
    function automatic int model_cmd(input logic [2:0] op, input int k, input logic [N-1:0] d, input logic s);
        logic [31:0] v;
        logic [15:0] r16;
        int r;
        int is_shift;
        is_shift = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6) ? 1 : 0;
        if (op == 3'd3) m_dout = d;
        if (op == 3'd7) m_dout = '0;
        if (is_shift == 1 && k > 0) begin
            r = k % N;
            case (op)
                3'd1, 3'd6: begin
                    v = {{24{(op == 3'd6) ? m_dout[N-1] : s}}, m_dout};
                    m_sout = v[k-1];
                    v = v >> k;
                    m_dout = v[N-1:0];
                end
                3'd2: begin
                    v = ({24'd0, m_dout} << k) | (s ? ((32'd1 << k) - 32'd1) : 32'd0);
                    m_dout = v[N-1:0];
                    m_sout = v[N];
                end
                3'd4: begin
                    r16 = ({8'd0, m_dout} >> r) | ({8'd0, m_dout} << (N - r));
                    m_dout = r16[N-1:0];
                    m_sout = m_dout[N-1];
                end
                default: begin
                    r16 = ({8'd0, m_dout} << r) | ({8'd0, m_dout} >> (N - r));
                    m_dout = r16[N-1:0] | r16[15:8];
                    m_sout = m_dout[0];
                end
            endcase
        end
        return (is_shift == 1 && k >= 2) ? k - 1 : 0;
    endfunction

    initial begin
        vec_t vecs[12];
        int waits;
        int done_cnt;
        int exp_wait;
        logic [2:0] r_op;
        logic [AMT_W-1:0] r_amt;
        logic [N-1:0] r_d;
        logic r_s;

        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{3'd3, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0};
        vecs[1]  = '{3'd1, 4'd0, 8'h00, 1'b1, 8'hA5, 1'b0, 0};
        vecs[2]  = '{3'd3, 4'd5, 8'hA5, 1'b0, 8'hA5, 1'b0, 0};
        vecs[3]  = '{3'd1, 4'd3, 8'h00, 1'b1, 8'hF4, 1'b1, 2};
        vecs[4]  = '{3'd3, 4'd0, 8'h96, 1'b0, 8'h96, 1'b1, 0};
        vecs[5]  = '{3'd6, 4'd2, 8'h00, 1'b0, 8'hE5, 1'b1, 1};
        vecs[6]  = '{3'd2, 4'd1, 8'h00, 1'b0, 8'hCA, 1'b1, 0};
        vecs[7]  = '{3'd7, 4'd9, 8'h55, 1'b1, 8'h00, 1'b1, 0};
        vecs[8]  = '{3'd0, 4'd7, 8'h55, 1'b1, 8'h00, 1'b1, 0};
        vecs[9]  = '{3'd3, 4'd0, 8'h81, 1'b0, 8'h81, 1'b1, 0};
        vecs[10] = '{3'd4, 4'd9, 8'h00, 1'b0, 8'hC0, 1'b1, 8};
        vecs[11] = '{3'd2, 4'd15, 8'h00, 1'b1, 8'hFF, 1'b1, 14};

        // Reset held for two cycles while the command inputs wander.
        rst = 1'b1;
        sin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 3'($urandom);
            cmd_amt   = AMT_W'($urandom);
            din       = N'($urandom);
            sin       = 1'($urandom);
            step_clk();
        end
        check_output("rst dout", 32'(dout), 32'h0);
        check_output("rst sout", 32'(sout), 32'h0);
        check_output("rst done", 32'(done), 32'h0);
        check_output("rst ready", 32'(cmd_ready), 32'h1);
        check_output("rst busy", 32'(busy), 32'h0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        step_clk();
        check_output("post rst done", 32'(done), 32'h0);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].s,
                           vecs[i].exp_dout, vecs[i].exp_sout, vecs[i].exp_wait);
        end

        // ROTL by 8 with a LOAD held on the port during the whole operation.
        apply_stimulus("load a5", 3'd3, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b1, 0);
        step_clk();
        check_output("done one cycle", 32'(done), 32'h0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_amt   = 4'd8;
        step_clk();
        cmd_op    = 3'd3;
        cmd_amt   = 4'd0;
        din       = 8'h00;
        waits     = 0;
        done_cnt  = 0;
        while (!done && waits < 40) begin
            step_clk();
            waits++;
        end
        check_output("rotl8 wait", 32'(waits), 32'd7);
        check_output("rotl8 dout", 32'(dout), 32'hA5);
        check_output("rotl8 sout", 32'(sout), 32'h1);
        step_clk();
        cmd_valid = 1'b0;
        check_output("held load dout", 32'(dout), 32'h00);
        check_output("held load done", 32'(done), 32'h1);

        // Reset in the middle of a SHL: the command is dropped without done.
        apply_stimulus("load ff", 3'd3, 4'd0, 8'hFF, 1'b0, 8'hFF, 1'b1, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_amt   = 4'd6;
        sin       = 1'b0;
        step_clk();
        cmd_valid = 1'b0;
        step_clk();
        check_output("shl mid dout", 32'(dout), 32'hFC);
        check_output("shl mid busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        check_output("abort dout", 32'(dout), 32'h00);
        check_output("abort sout", 32'(sout), 32'h0);
        check_output("abort ready", 32'(cmd_ready), 32'h1);
        check_output("abort busy", 32'(busy), 32'h0);
        done_cnt = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            step_clk();
            if (done === 1'b1) done_cnt++;
        end
        check_output("abort no done", 32'(done_cnt), 32'd0);

        // Random commands against the arithmetic model.
        m_dout = '0;
        m_sout = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r_op     = 3'($urandom_range(0, 7));
            r_amt    = AMT_W'($urandom_range(0, 15));
            r_d      = N'($urandom);
            r_s      = 1'($urandom);
            exp_wait = model_cmd(r_op, int'(r_amt), r_d, r_s);
            apply_stimulus($sformatf("rnd%0d op%0d amt%0d", i, r_op, r_amt), r_op, r_amt, r_d, r_s,
                           m_dout, m_sout, exp_wait);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
